// File: rtl/fp_align.sv
// rtl/fp_align.sv - IEEE-754 single-precision operand alignment ahead of the mantissa adder
//
// Purpose: unpacks two single-precision operands and right-shifts the significand
// of the operand with the smaller effective exponent, one bit per cycle, until both
// share the larger exponent. Bits lost off the bottom are collected in sticky.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   a_in, b_in           32-bit IEEE-754 operands
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   sig_a, sig_b         aligned 24-bit significands {hidden, fraction}, in operand order
//   exp_out              common (larger effective) exponent
//   sign_a, sign_b       operand signs
//   sticky               OR of every bit shifted out of the smaller operand
//   special              either operand has an all-ones exponent (Inf/NaN)

module fp_align (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] sig_a,
  output logic [23:0] sig_b,
  output logic [7:0]  exp_out,
  output logic        sign_a,
  output logic        sign_b,
  output logic        sticky,
  output logic        special
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  counter;
  logic        shift_b;   // 1: B is the smaller operand and is being shifted

  // Unpacked view of the incoming pair, only used on the accept edge.
  logic [7:0]  eff_a, eff_b;
  logic [23:0] raw_a, raw_b;
  logic        a_big;
  logic [7:0]  d;
  logic        spec_in;

  always_comb begin
    eff_a   = (a_in[30:23] == 8'd0) ? 8'd1 : a_in[30:23];
    eff_b   = (b_in[30:23] == 8'd0) ? 8'd1 : b_in[30:23];
    raw_a   = {(a_in[30:23] != 8'd0), a_in[22:0]};
    raw_b   = {(b_in[30:23] != 8'd0), b_in[22:0]};
    a_big   = (eff_a >= eff_b);
    d       = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
    spec_in = (a_in[30:23] == 8'hFF) || (b_in[30:23] == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sig_a     <= 24'd0;
      sig_b     <= 24'd0;
      exp_out   <= 8'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      sticky    <= 1'b0;
      special   <= 1'b0;
      counter   <= 5'd0;
      shift_b   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_a   <= a_in[31];
            sign_b   <= b_in[31];
            special  <= spec_in;
            exp_out  <= a_big ? eff_a : eff_b;
            shift_b  <= a_big;
            in_ready <= 1'b0;
            sticky   <= 1'b0;
            counter  <= 5'd0;
            sig_a    <= raw_a;
            sig_b    <= raw_b;
            if (spec_in || d == 8'd0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (d <= 8'd24) begin
              state   <= SHIFT;
              counter <= d[4:0];
            end else begin
              // Everything falls off the bottom: smaller significand collapses into sticky.
              state     <= DONE;
              out_valid <= 1'b1;
              if (a_big) begin
                sig_b  <= 24'd0;
                sticky <= |raw_b;
              end else begin
                sig_a  <= 24'd0;
                sticky <= |raw_a;
              end
            end
          end
        end

        SHIFT: begin
          if (shift_b) begin
            sig_b  <= sig_b >> 1;
            sticky <= sticky | sig_b[0];
          end else begin
            sig_a  <= sig_a >> 1;
            sticky <= sticky | sig_a[0];
          end
          counter <= counter - 5'd1;
          if (counter == 5'd1) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align.sv
// tb/tb_fp_align.sv - directed self-checking bench for fp_align

module tb_fp_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in, b_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] sig_a, sig_b;
  logic [7:0]  exp_out;
  logic        sign_a, sign_b, sticky, special;

  int passed = 0;
  int total  = 0;
  int lat;

  fp_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .exp_out   (exp_out),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .sticky    (sticky),
    .special   (special)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Present a pair for one accept cycle, then count cycles until out_valid (bounded).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int cycles);
    @(negedge clk);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = 32'hDEADBEEF;
    b_in = 32'h12345678;
    cycles = 1;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] ea, input logic [23:0] eb,
                         input logic [7:0] ee, input logic es, input logic esp);
    chk({tag, "_valid"},   {31'd0, out_valid}, 32'd1);
    chk({tag, "_sig_a"},   {8'd0, sig_a}, {8'd0, ea});
    chk({tag, "_sig_b"},   {8'd0, sig_b}, {8'd0, eb});
    chk({tag, "_exp"},     {24'd0, exp_out}, {24'd0, ee});
    chk({tag, "_sticky"},  {31'd0, sticky}, {31'd0, es});
    chk({tag, "_special"}, {31'd0, special}, {31'd0, esp});
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_ret_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ret_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a_in = 32'h3F800000;
    b_in = 32'h40000000;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sig_a", {8'd0, sig_a}, 32'd0);
    chk("rst_sig_b", {8'd0, sig_b}, 32'd0);
    chk("rst_exp", {24'd0, exp_out}, 32'd0);
    chk("rst_flags", {28'd0, sign_a, sign_b, sticky, special}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // d=1, A shifted
    issue(32'h3F800000, 32'h40000000, lat);
    chk("d1_latency", lat, 2);
    chk_out("d1", 24'h400000, 24'h800000, 8'h80, 1'b0, 1'b0);
    chk_idle("d1");

    // d=0
    issue(32'h3FC00000, 32'h3F800000, lat);
    chk("d0_latency", lat, 1);
    chk_out("d0", 24'hC00000, 24'h800000, 8'h7F, 1'b0, 1'b0);
    chk_idle("d0");

    // denormal vs smallest normal, both effective exponent 1
    issue(32'h00000001, 32'h00800000, lat);
    chk("denorm_latency", lat, 1);
    chk_out("denorm", 24'h000001, 24'h800000, 8'h01, 1'b0, 1'b0);
    chk_idle("denorm");

    // d=3, B shifted, low bit lost into sticky
    issue(32'h41000000, 32'h3FC00001, lat);
    chk("d3_latency", lat, 4);
    chk_out("d3", 24'h800000, 24'h180000, 8'h82, 1'b1, 1'b0);
    chk_idle("d3");

    // d=24, boundary of shifting path
    issue(32'h4B800000, 32'h3F800001, lat);
    chk("d24_latency", lat, 25);
    chk_out("d24", 24'h800000, 24'h000000, 8'h97, 1'b1, 1'b0);
    chk_idle("d24");

    // d=25, immediate collapse
    issue(32'h4C000000, 32'h3F800000, lat);
    chk("d25_latency", lat, 1);
    chk_out("d25", 24'h800000, 24'h000000, 8'h98, 1'b1, 1'b0);
    chk_idle("d25");

    // Inf operand
    issue(32'h7F800000, 32'h3F800000, lat);
    chk("inf_latency", lat, 1);
    chk_out("inf", 24'h800000, 24'h800000, 8'hFF, 1'b0, 1'b1);
    chk_idle("inf");

    // signs pass through, A negative and shifted
    issue(32'hBF800000, 32'h40000000, lat);
    chk("sign_latency", lat, 2);
    chk("sign_a", {31'd0, sign_a}, 32'd1);
    chk("sign_b", {31'd0, sign_b}, 32'd0);
    chk_out("sign", 24'h400000, 24'h800000, 8'h80, 1'b0, 1'b0);
    chk_idle("sign");

    // backpressure: result held for 5 cycles, new inputs ignored
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, lat);
    chk("bp_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_in = 32'h7F800000;
      b_in = 32'h00000001;
      @(negedge clk);
      chk_out("bp_hold", 24'h400000, 24'h800000, 8'h80, 1'b0, 1'b0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk_idle("bp");

    // reset in the 10th SHIFT cycle of a d=24 operation
    @(negedge clk);
    a_in = 32'h4B800000;
    b_in = 32'h3F800001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_still_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_sigs", {sig_a, 8'd0} | {8'd0, sig_b}, 32'd0);
    chk("mid_rst_exp", {24'd0, exp_out}, 32'd0);
    chk("mid_rst_flags", {28'd0, sign_a, sign_b, sticky, special}, 32'd0);
    issue(32'h3FC00000, 32'h3F800000, lat);
    chk("after_rst_latency", lat, 1);
    chk_out("after_rst", 24'hC00000, 24'h800000, 8'h7F, 1'b0, 1'b0);
    chk_idle("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
